// File: rtl/serial_in_parallel_out_deserializer_pkg.sv
// Shared definitions for the serial-in / parallel-out deserializer.
// Contents:
//   DEFAULT_DATA_WIDTH - default word width, the same as the PISO transmitter
//   buf_state_e        - state encoding of the one-deep output buffer
package serial_in_parallel_out_deserializer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [0:0] {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/serial_in_parallel_out_deserializer_if.sv
// Word-side bus of the deserializer: the assembled word, its handshake, and
// a debug view of the output-buffer state.
// Signals:
//   Parallel_Data_Out  - assembled word (producer -> consumer)
//   Parallel_Valid_Out - buffer holds an unconsumed word (producer -> consumer)
//   Parallel_Ready_In  - consumer can take the word (consumer -> producer)
//   buf_state          - output-buffer FSM state, for observation only
// Modports: master (deserializer side), slave (consumer side).
//
// Handshake: a word transfers on a rising edge where Parallel_Valid_Out and
// Parallel_Ready_In are both 1. Once valid is raised it stays high, and the
// data stays unchanged, until that transfer happens. Ready may change freely
// and is allowed to depend on valid.
interface serial_in_parallel_out_deserializer_if
  import serial_in_parallel_out_deserializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] Parallel_Data_Out;
  logic                  Parallel_Valid_Out;
  logic                  Parallel_Ready_In;
  logic [0:0]            buf_state;

  modport master (
    output Parallel_Data_Out,
    output Parallel_Valid_Out,
    output buf_state,
    input  Parallel_Ready_In
  );

  modport slave (
    input  Parallel_Data_Out,
    input  Parallel_Valid_Out,
    input  buf_state,
    output Parallel_Ready_In
  );

endinterface

// File: rtl/serial_in_parallel_out_deserializer_output_buffer.sv
// One-deep valid/ready holding register for completed words.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   load      - a completed word is offered this cycle
//   load_data - the completed word
//   bus       - word-side bus (master modport): data, valid, ready, state
//   overrun   - sticky: a completed word arrived while the buffer was full
//               and not being drained; only rst clears it
module sipo_output_buffer
  import serial_in_parallel_out_deserializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  serial_in_parallel_out_deserializer_if.master bus,
  output logic                  overrun
);

  localparam logic [0:0] ST_EMPTY = BUF_EMPTY;
  localparam logic [0:0] ST_FULL  = BUF_FULL;

  logic [0:0]            state_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (load) begin
            data_q  <= load_data;
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (bus.Parallel_Ready_In) begin
            // The current word leaves this edge; a word completing on the
            // same edge takes its place without a bubble.
            if (load) begin
              data_q <= load_data;
            end else begin
              state_q <= ST_EMPTY;
            end
          end else if (load) begin
            // Keep the unconsumed word and drop the new one.
            overrun_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
        end
      endcase
    end
  end

  assign bus.Parallel_Data_Out  = data_q;
  assign bus.Parallel_Valid_Out = (state_q == ST_FULL);
  assign bus.buf_state          = state_q;
  assign overrun                = overrun_q;

endmodule

// File: rtl/serial_in_parallel_out_deserializer.sv
// Receive side of a PISO link: collects a qualified serial stream, LSB of
// each word first, into DATA_WIDTH-bit words and hands them to a one-deep
// valid/ready output buffer.
// Ports:
//   Clk_In          - clock, rising edge
//   Reset_In        - synchronous active-high reset, dominates all inputs
//   Sync_Clear_In   - drop the partial word and restart the bit count;
//                     the output buffer is not touched
//   Serial_Valid_In - Serial_Data_In carries a bit this cycle
//   Serial_Data_In  - serial bit
//   bus             - word side (data, valid, ready, buffer state)
//   Bit_Count_Out   - bits held in the current partial word
//   Overrun_Out     - sticky: a completed word was dropped
module serial_in_parallel_out_deserializer
  import serial_in_parallel_out_deserializer_pkg::*;
#(
  parameter int  DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  localparam int COUNT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   Clk_In,
  input  logic                   Reset_In,
  input  logic                   Sync_Clear_In,
  input  logic                   Serial_Valid_In,
  input  logic                   Serial_Data_In,
  serial_in_parallel_out_deserializer_if.master bus,
  output logic [COUNT_WIDTH-1:0] Bit_Count_Out,
  output logic                   Overrun_Out
);

  localparam logic [COUNT_WIDTH-1:0] LAST_BIT = COUNT_WIDTH'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0]  shreg_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [DATA_WIDTH-1:0]  shreg_next;
  logic                   complete;

  // Right shift: after DATA_WIDTH bits the first bit received sits at bit 0.
  assign shreg_next = {Serial_Data_In, shreg_q[DATA_WIDTH-1:1]};

  // A clear in the same cycle swallows the bit, so it cannot complete a word.
  assign complete = Serial_Valid_In && !Sync_Clear_In && (count_q == LAST_BIT);

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      shreg_q <= '0;
      count_q <= '0;
    end else if (Sync_Clear_In) begin
      shreg_q <= '0;
      count_q <= '0;
    end else if (Serial_Valid_In) begin
      shreg_q <= shreg_next;
      // Explicit wrap keeps non-power-of-two widths correct.
      count_q <= (count_q == LAST_BIT) ? '0 : count_q + COUNT_WIDTH'(1);
    end
  end

  sipo_output_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_output_buffer (
    .clk       (Clk_In),
    .rst       (Reset_In),
    .load      (complete),
    .load_data (shreg_next),
    .bus       (bus),
    .overrun   (Overrun_Out)
  );

  assign Bit_Count_Out = count_q;

endmodule

// File: tb/tb_serial_in_parallel_out_deserializer.sv
module tb_serial_in_parallel_out_deserializer;

  localparam int W  = 32;
  localparam int CW = $clog2(W);

  // ---------------- clock / reset ----------------
  logic Clk_In = 1'b0;
  always #5 Clk_In = ~Clk_In;

  logic          Reset_In        = 1'b1;
  logic          Sync_Clear_In   = 1'b0;
  logic          Serial_Valid_In = 1'b0;
  logic          Serial_Data_In  = 1'b0;
  logic [CW-1:0] Bit_Count_Out;
  logic          Overrun_Out;

  serial_in_parallel_out_deserializer_if #(.DATA_WIDTH(W)) bus ();

  serial_in_parallel_out_deserializer #(.DATA_WIDTH(W)) dut (
    .Clk_In          (Clk_In),
    .Reset_In        (Reset_In),
    .Sync_Clear_In   (Sync_Clear_In),
    .Serial_Valid_In (Serial_Valid_In),
    .Serial_Data_In  (Serial_Data_In),
    .bus             (bus),
    .Bit_Count_Out   (Bit_Count_Out),
    .Overrun_Out     (Overrun_Out)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Partial word kept as a list of received bits; the count is its length.
  bit           bits_q[$];
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;
  logic         m_ovr   = 1'b0;
  logic [W-1:0] exp_q[$];          // words the consumer must still receive
  int           cyc = 0;
  int           valid_cycles[$];   // cycles at which valid was seen high

  function automatic logic [W-1:0] bits_to_word();
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) if (bits_q[i]) w = w | (W'(1) << i);
    return w;
  endfunction

  task automatic model_edge(input logic rst, input logic clr, input logic sv,
                            input logic sd, input logic rdy);
    logic         done = 1'b0;
    logic [W-1:0] word = '0;
    if (rst) begin
      bits_q.delete();
      exp_q.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_ovr   = 1'b0;
      return;
    end
    if (clr) begin
      bits_q.delete();
    end else if (sv) begin
      bits_q.push_back(sd);
      if (bits_q.size() == W) begin
        word = bits_to_word();
        bits_q.delete();
        done = 1'b1;
      end
    end
    if (m_valid && rdy) m_valid = 1'b0;
    if (done) begin
      if (!m_valid) begin
        m_valid = 1'b1;
        m_data  = word;
        exp_q.push_back(word);
      end else begin
        m_ovr = 1'b1;
      end
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: apply inputs, score any handshake, step the model,
  // then compare all outputs 1 time unit after the edge.
  task automatic tick(input logic rst, input logic clr, input logic sv,
                      input logic sd, input logic rdy);
    logic [W-1:0] front;
    Reset_In              = rst;
    Sync_Clear_In         = clr;
    Serial_Valid_In       = sv;
    Serial_Data_In        = sd;
    bus.Parallel_Ready_In = rdy;
    #1;
    if (!rst && bus.Parallel_Valid_Out && rdy) begin
      check_eq("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        front = exp_q.pop_front();
        check_eq("sb_word", 64'(bus.Parallel_Data_Out), 64'(front));
      end
    end
    @(posedge Clk_In);
    model_edge(rst, clr, sv, sd, rdy);
    cyc++;
    #1;
    check_eq("valid", 64'(bus.Parallel_Valid_Out), 64'(m_valid));
    check_eq("data", 64'(bus.Parallel_Data_Out), 64'(m_data));
    check_eq("count", 64'(Bit_Count_Out), 64'(bits_q.size()));
    check_eq("overrun", 64'(Overrun_Out), 64'(m_ovr));
    if (bus.Parallel_Valid_Out) valid_cycles.push_back(cyc);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rdy);
    for (int i = 0; i < W; i++) tick(1'b0, 1'b0, 1'b1, w[i], rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] w;

    // 1: reset, then one word with ready high
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("t1_rst_valid", 64'(bus.Parallel_Valid_Out), 64'd0);
    check_eq("t1_rst_data", 64'(bus.Parallel_Data_Out), 64'd0);
    check_eq("t1_rst_count", 64'(Bit_Count_Out), 64'd0);
    check_eq("t1_rst_ovr", 64'(Overrun_Out), 64'd0);
    send_word(32'hA5A5F00D, 1'b1);
    check_eq("t1_valid", 64'(bus.Parallel_Valid_Out), 64'd1);
    check_eq("t1_data", 64'(bus.Parallel_Data_Out), 64'hA5A5F00D);
    check_eq("t1_count", 64'(Bit_Count_Out), 64'd0);
    idle(1, 1'b1);
    check_eq("t1_valid_drop", 64'(bus.Parallel_Valid_Out), 64'd0);
    check_eq("t1_count_after", 64'(Bit_Count_Out), 64'd0);

    // 2: gaps of 3 cycles after bits 7 and 20
    w = 32'hA5A5F00D;
    for (int i = 0; i < W; i++) begin
      tick(1'b0, 1'b0, 1'b1, w[i], 1'b1);
      if (i == 7 || i == 20) begin
        for (int g = 0; g < 3; g++) begin
          tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
          check_eq("t2_gap_count", 64'(Bit_Count_Out), 64'(i + 1));
        end
      end
    end
    check_eq("t2_data", 64'(bus.Parallel_Data_Out), 64'hA5A5F00D);
    check_eq("t2_valid", 64'(bus.Parallel_Valid_Out), 64'd1);
    idle(1, 1'b1);

    // 3: back-to-back words, valid edges exactly W cycles apart
    valid_cycles.delete();
    send_word(32'h00000001, 1'b1);
    send_word(32'hFFFFFFFE, 1'b1);
    check_eq("t3_data", 64'(bus.Parallel_Data_Out), 64'hFFFFFFFE);
    check_eq("t3_nvalid", 64'(valid_cycles.size()), 64'd2);
    if (valid_cycles.size() == 2)
      check_eq("t3_spacing", 64'(valid_cycles[1] - valid_cycles[0]), 64'(W));
    check_eq("t3_ovr", 64'(Overrun_Out), 64'd0);
    idle(1, 1'b1);

    // 4: consumer stalled across two words
    send_word(32'h12345678, 1'b0);
    send_word(32'h9ABCDEF0, 1'b0);
    check_eq("t4_hold", 64'(bus.Parallel_Data_Out), 64'h12345678);
    check_eq("t4_ovr", 64'(Overrun_Out), 64'd1);
    valid_cycles.delete();
    idle(1, 1'b1);
    check_eq("t4_valid_drop", 64'(bus.Parallel_Valid_Out), 64'd0);
    idle(3, 1'b1);
    check_eq("t4_never_shown", 64'(valid_cycles.size()), 64'd0);
    check_eq("t4_ovr_sticky", 64'(Overrun_Out), 64'd1);

    // 5a: reset in mid-word
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b1, 1'($urandom_range(1)), 1'b1);
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("t5_rst_count", 64'(Bit_Count_Out), 64'd0);
    check_eq("t5_rst_ovr", 64'(Overrun_Out), 64'd0);
    check_eq("t5_rst_data", 64'(bus.Parallel_Data_Out), 64'd0);
    send_word(32'hCAFEBABE, 1'b1);
    check_eq("t5_word", 64'(bus.Parallel_Data_Out), 64'hCAFEBABE);
    idle(1, 1'b1);
    // 5b: sync clear while a word is held
    send_word(32'h11112222, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b1, 1'($urandom_range(1)), 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t5_clr_count", 64'(Bit_Count_Out), 64'd0);
    check_eq("t5_clr_hold", 64'(bus.Parallel_Data_Out), 64'h11112222);
    check_eq("t5_clr_valid", 64'(bus.Parallel_Valid_Out), 64'd1);
    idle(1, 1'b1);
    send_word(32'hCAFEBABE, 1'b1);
    check_eq("t5_clr_word", 64'(bus.Parallel_Data_Out), 64'hCAFEBABE);
    idle(1, 1'b1);

    // 6: clear collides with the last bit
    w = 32'h0F0F3C3C;
    for (int i = 0; i < W - 1; i++) tick(1'b0, 1'b0, 1'b1, w[i], 1'b1);
    tick(1'b0, 1'b1, 1'b1, w[W-1], 1'b1);
    check_eq("t6_valid", 64'(bus.Parallel_Valid_Out), 64'd0);
    check_eq("t6_count", 64'(Bit_Count_Out), 64'd0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      tick(1'($urandom_range(199) == 0), 1'($urandom_range(59) == 0),
           1'($urandom_range(3) != 0), 1'($urandom_range(1)),
           1'($urandom_range(2) != 0));
    end
    idle(3, 1'b1);
    check_eq("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_in_parallel_out_deserializer.md
Name: serial_in_parallel_out_deserializer

Overview:
Receive-side counterpart to the team's 32-bit PISO shift register. Accepts a qualified serial bit stream, LSB first, matching the PISO's bit-0-first shift order. Assembles each DATA_WIDTH-bit word and presents it on a one-deep output buffer with a valid/ready handshake. It sits at the far end of a PISO link, ahead of word-level consumers.

Parameters:
DATA_WIDTH, 32, word width in bits; must be ≥2.
COUNT_WIDTH, $clog2(DATA_WIDTH), width of the bit counter; derived, not overridden.

Ports:
Clk_In  input  1  clock; all state updates on the rising edge.
Reset_In  input  1  synchronous, active-high reset.
Sync_Clear_In  input  1  discards the partial word and restarts the bit count; output buffer untouched.
Serial_Valid_In  input  1  qualifies Serial_Data_In in the current cycle.
Serial_Data_In  input  1  serial bit, LSB of each word first.
Parallel_Data_Out  output  DATA_WIDTH  assembled word; stable while Parallel_Valid_Out=1.
Parallel_Valid_Out  output  1  output buffer holds an unconsumed word.
Parallel_Ready_In  input  1  consumer accepts the word when high with Parallel_Valid_Out.
Bit_Count_Out  output  COUNT_WIDTH  bits received in the current partial word (0..DATA_WIDTH-1).
Overrun_Out  output  1  sticky flag: a completed word was dropped.

Behaviour:
- Clock and reset: one clock (Clk_In); Reset_In is synchronous and active-high, sampled on the rising edge.
- Reset values: shift register 0, Bit_Count_Out 0, Parallel_Data_Out 0, Parallel_Valid_Out 0, Overrun_Out 0.
- Reset dominates every other input in the same cycle.
- Shift: when Serial_Valid_In=1, the shift register takes {Serial_Data_In, shreg[DATA_WIDTH-1:1]} (right shift, new bit enters at the MSB) and the count increments. With Serial_Valid_In=0, the register and count hold.
- Completion: Serial_Valid_In=1 with count = DATA_WIDTH-1 completes a word.
  - The completed word is {Serial_Data_In, shreg[DATA_WIDTH-1:1]}.
  - The count wraps to 0 and the shift register is not required to clear.
  - Latency is 1 cycle: the word appears on Parallel_Data_Out, with Parallel_Valid_Out=1, on the edge that samples the last bit.
- Output buffer FSM, two states:
  - EMPTY: Parallel_Valid_Out=0. On completion, load the word and go to FULL.
  - FULL: Parallel_Valid_Out=1 and data held.
    - Ready=1, no completion: go to EMPTY.
    - Ready=1 with completion in the same cycle: load the new word and stay FULL (back-to-back, no bubble).
    - Ready=0 with completion: drop the new word, keep the old one, set Overrun_Out.
- Overrun_Out stays set until Reset_In. Sync_Clear_In does not clear it.
- Sync_Clear_In:
  - Forces count 0 and shift register 0 on the next edge.
  - Takes priority over a same-cycle serial bit; that bit is discarded and no completion occurs.
  - Does not affect Parallel_Data_Out, Parallel_Valid_Out or the handshake.
- Reset mid-word: the partial word is lost and the next qualified bit is treated as bit 0.
- Parallel_Data_Out only updates on a load; it never changes while valid is high without a handshake.

Decomposition:
- Shared package:
  - The output-buffer state enum (BUF_EMPTY, BUF_FULL).
  - Default DATA_WIDTH constant (32), shared with the PISO side.
- One sub-module, sipo_output_buffer: the one-deep valid/ready holding register, including the overrun flag.
- The shift register and bit counter stay in the top module.

Test Plan:
1. Reset, then 32 consecutive valid bits of 0xA5A5F00D LSB first, Ready=1 → on the 32nd-bit edge: Parallel_Data_Out=0xA5A5F00D, Valid=1. Next cycle Valid=0; Bit_Count_Out=0 throughout the handoff.
2. Same word with Serial_Valid_In deasserted for 3 cycles after bits 7 and 20 → identical output, completion delayed by 6 cycles; Bit_Count_Out holds at 8 and 21 during the gaps.
3. Continuous stream of 0x00000001 then 0xFFFFFFFE with Ready=1 → both words delivered, Valid high on two edges exactly 32 cycles apart, Overrun_Out=0.
4. Ready=0; send 0x12345678 then 0x9ABCDEF0 → output holds 0x12345678 and Overrun_Out=1 after the second word completes. Raising Ready drops Valid; 0x9ABCDEF0 is never presented.
5. Send 10 bits, assert Reset_In for 1 cycle, then send 0xCAFEBABE → all outputs 0 after reset; next word 0xCAFEBABE correct. Repeat using Sync_Clear_In with a held valid word: the held word is unchanged and the new word is correct.
6. Sync_Clear_In and Serial_Valid_In high on the bit-31 cycle → no completion, Valid stays 0, Bit_Count_Out=0.
